// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the system PLL: holds the PLL in reset, waits for a
// stable synchronized lock, then releases the downstream reset; re-sequences on loss/timeout/request.
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES     = 10,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       timeout_err,
    output logic [7:0] relock_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             sync1_q, lock_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             timeout_err_q, timeout_err_d;
    logic [7:0]       relock_count_q, relock_count_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        timeout_err_d  = timeout_err_q;
        relock_count_d = relock_count_q;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT: begin
                // Stability completion takes priority over a coincident timeout.
                if (lock_s_q && (cnt_q == STABLE_LAST)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d       = ST_HOLD;
                    cnt_d         = '0;
                    tmo_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + CNT_ONE;
                    cnt_d = lock_s_q ? (cnt_q + CNT_ONE) : '0;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    if (relock_count_q != 8'hFF) begin
                        relock_count_d = relock_count_q + 8'd1;
                    end
                end else if (relock_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                tmo_d   = '0;
            end
        endcase
        // Outputs are registered from the next state so they move with the state register.
        pll_rst_d = (state_d == ST_HOLD);
        sys_rst_d = (state_d != ST_RUN);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q        <= ST_HOLD;
            cnt_q          <= '0;
            tmo_q          <= '0;
            sync1_q        <= 1'b0;
            lock_s_q       <= 1'b0;
            pll_rst_q      <= 1'b1;
            sys_rst_q      <= 1'b1;
            timeout_err_q  <= 1'b0;
            relock_count_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            sync1_q        <= pll_locked;
            lock_s_q       <= sync1_q;
            pll_rst_q      <= pll_rst_d;
            sys_rst_q      <= sys_rst_d;
            timeout_err_q  <= timeout_err_d;
            relock_count_q <= relock_count_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ~sys_rst_q;
    assign timeout_err  = timeout_err_q;
    assign relock_count = relock_count_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: table-driven bring-up plus hand-written sequences for
// relock, glitch, timeout, saturation and reset corner cases.
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       timeout_err;
    logic [7:0] relock_count;
    logic [1:0] state_dbg;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .CNT_W              (16)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .timeout_err (timeout_err),
        .relock_count(relock_count),
        .state_dbg   (state_dbg)
    );

    // Clock / reset block
    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    // Expected word: {pll_rst, sys_rst, ready, timeout_err, relock_count}
    localparam int W = 12;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;

    typedef struct {
        logic         r;
        logic         lk;
        logic         req;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [W-1:0] e_hold(input logic te, input logic [7:0] c);
        return {1'b1, 1'b1, 1'b0, te, c};
    endfunction
    function automatic logic [W-1:0] e_wait(input logic te, input logic [7:0] c);
        return {1'b0, 1'b1, 1'b0, te, c};
    endfunction
    function automatic logic [W-1:0] e_run(input logic te, input logic [7:0] c);
        return {1'b0, 1'b0, 1'b1, te, c};
    endfunction

    function automatic void add_vec(input logic r, input logic lk, input logic req, input logic [W-1:0] exp);
        vec_t v;
        v.r = r; v.lk = lk; v.req = req; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // Driver: apply inputs for one edge, queue the expected post-edge outputs, then check.
    task automatic step(input logic r, input logic lk, input logic req, input logic [W-1:0] exp, input string name);
        logic [W-1:0] got;
        logic [W-1:0] want;
        rst        = r;
        pll_locked = lk;
        relock_req = req;
        exp_q.push_back(exp);
        @(posedge refclk);
        #1;
        got  = {pll_rst, sys_rst, ready, timeout_err, relock_count};
        want = exp_q.pop_front();
        checks++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL %s @%0t: got pll_rst/sys_rst/ready/timeout_err/relock_count=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                     name, $time, got[11], got[10], got[9], got[8], got[7:0],
                     want[11], want[10], want[9], want[8], want[7:0]);
        end
    endtask

    // From the edge that entered HOLD: 3 more HOLD edges, 8 WAIT edges, then RUN.
    task automatic bringup(input logic te, input logic [7:0] c, input int req_j);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, e_hold(te, c), "bringup_hold");
        for (int j = 0; j < 8; j++) step(1'b0, 1'b1, (j == req_j), e_wait(te, c), "bringup_wait");
        step(1'b0, 1'b1, 1'b0, e_run(te, c), "bringup_ready");
    endtask

    // Drop pll_locked for 2 cycles in RUN: HOLD appears on the third edge.
    task automatic lose_lock(input logic te, input logic [7:0] c_before, input logic req_same, output logic [7:0] c_after);
        c_after = (c_before == 8'd255) ? 8'd255 : c_before + 8'd1;
        step(1'b0, 1'b0, 1'b0, e_run(te, c_before), "loss_still_run1");
        step(1'b0, 1'b0, 1'b0, e_run(te, c_before), "loss_still_run2");
        step(1'b0, 1'b1, req_same, e_hold(te, c_after), "loss_hold");
        bringup(te, c_after, -1);
    endtask

    initial begin
        logic [7:0] c;
        logic       te;
        rst = 1'b1; pll_locked = 1'b1; relock_req = 1'b0;

        // Normal bring-up table
        for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b1, 1'b0, e_hold(1'b0, 8'd0));
        for (int i = 1; i <= 3; i++) add_vec(1'b0, 1'b1, 1'b0, e_hold(1'b0, 8'd0));
        for (int i = 4; i <= 11; i++) add_vec(1'b0, 1'b1, 1'b0, e_wait(1'b0, 8'd0));
        add_vec(1'b0, 1'b1, 1'b0, e_run(1'b0, 8'd0));
        add_vec(1'b0, 1'b1, 1'b0, e_run(1'b0, 8'd0));
        foreach (vecs[i]) step(vecs[i].r, vecs[i].lk, vecs[i].req, vecs[i].exp, $sformatf("table[%0d]", i));

        // relock_req in RUN, then a relock_req pulse during WAIT that must be ignored
        step(1'b0, 1'b1, 1'b1, e_hold(1'b0, 8'd0), "relock_req_run");
        bringup(1'b0, 8'd0, 3);

        // Glitch: pll_locked low for one cycle after 5 stable WAIT cycles
        step(1'b0, 1'b1, 1'b1, e_hold(1'b0, 8'd0), "glitch_req");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, e_hold(1'b0, 8'd0), "glitch_hold");
        for (int j = 0; j < 15; j++) step(1'b0, (j != 5), 1'b0, e_wait(1'b0, 8'd0), "glitch_wait");
        step(1'b0, 1'b1, 1'b0, e_run(1'b0, 8'd0), "glitch_ready");

        // Stability completes on the same edge the timeout expires: RUN, no error
        step(1'b0, 1'b1, 1'b1, e_hold(1'b0, 8'd0), "sim_req");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, e_hold(1'b0, 8'd0), "sim_hold");
        for (int j = 0; j < 32; j++) step(1'b0, (j >= 23), 1'b0, e_wait(1'b0, 8'd0), "sim_wait");
        step(1'b0, 1'b1, 1'b0, e_run(1'b0, 8'd0), "stable_beats_timeout");

        // Seven lock losses; the first coincides with relock_req
        c = 8'd0;
        for (int k = 0; k < 7; k++) lose_lock(1'b0, c, (k == 0), c);

        // Reset in RUN with relock_count=7, other inputs active
        step(1'b1, 1'b0, 1'b1, e_hold(1'b0, 8'd0), "rst_in_run");
        step(1'b1, 1'b1, 1'b0, e_hold(1'b0, 8'd0), "rst_held");
        bringup(1'b0, 8'd0, -1);

        // 260 lock losses: relock_count saturates at 255
        c = 8'd0;
        for (int k = 0; k < 260; k++) lose_lock(1'b0, c, 1'b0, c);

        // Lock never asserts: two full timeout periods, timeout_err sticky
        step(1'b0, 1'b0, 1'b0, e_run(1'b0, 8'd255), "tmo_run1");
        step(1'b0, 1'b0, 1'b0, e_run(1'b0, 8'd255), "tmo_run2");
        step(1'b0, 1'b0, 1'b0, e_hold(1'b0, 8'd255), "tmo_hold_sat");
        te = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, e_hold(te, 8'd255), "tmo_hold");
            for (int j = 0; j < 32; j++) step(1'b0, 1'b0, (j == 10), e_wait(te, 8'd255), "tmo_wait");
            step(1'b0, 1'b0, 1'b0, e_hold(1'b1, 8'd255), "timeout_hold");
            te = 1'b1;
        end
        // A later successful lock leaves timeout_err set
        bringup(1'b1, 8'd255, -1);

        // Reset in WAIT with timeout_err=1
        step(1'b0, 1'b1, 1'b1, e_hold(1'b1, 8'd255), "pre_rst_req");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, e_hold(1'b1, 8'd255), "pre_rst_hold");
        for (int j = 0; j < 2; j++) step(1'b0, 1'b1, 1'b0, e_wait(1'b1, 8'd255), "pre_rst_wait");
        step(1'b1, 1'b0, 1'b1, e_hold(1'b0, 8'd0), "rst_in_wait");
        step(1'b0, 1'b1, 1'b0, e_hold(1'b0, 8'd0), "hold_after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
